// File: rtl/light_ctrl_pkg.sv
// Shared types and constants for the light show sequencer and its benches.
package light_ctrl_pkg;

    typedef enum logic [1:0] {
        OFF,
        INIT,
        RUN,
        PAUSED
    } state_t;

    localparam int unsigned COLOUR_FIRST = 1;
    localparam int unsigned COLOUR_LAST  = 6;

    localparam logic [23:0] WHITE     = 24'hFFFFFF;
    localparam logic [23:0] FIRST_RGB = 24'h0000FF;

endpackage

// File: rtl/light_show_controller_dwell_timer.sv
// Dwell countdown: load has priority over decrement; otherwise the count holds.
module dwell_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/light_show_controller.sv
// Sequencer driving the lights selector one colour step per dwell period.
// Optional macro LIGHT_SHOW_BLANK_EN: sel_o drops for each button pulse cycle.
module light_show_controller #(
    parameter int unsigned DWELL_W      = 16,
    parameter int unsigned COLOUR_FIRST = light_ctrl_pkg::COLOUR_FIRST,
    parameter int unsigned COLOUR_LAST  = light_ctrl_pkg::COLOUR_LAST
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               pause,
    input  logic               step_req,
    input  logic [DWELL_W-1:0] dwell,
    output logic               sel_o,
    output logic               button_o,
    output logic               light_rst_o,
    output logic [2:0]         colour_idx,
    output logic               running
);

    import light_ctrl_pkg::*;

    state_t       state_q, state_d;
    logic         sel_q, sel_d;
    logic         button_q, button_d;
    logic         lrst_q, lrst_d;
    logic         running_q, running_d;
    logic [2:0]   colour_q, colour_d;

    logic               tmr_load, tmr_dec, tmr_zero, advance;
    logic [DWELL_W-1:0] reload_val;

    // A dwell of 0 behaves as 1, i.e. a reload value of 0.
    assign reload_val = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    dwell_timer #(
        .W (DWELL_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (reload_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d   = state_q;
        colour_d  = colour_q;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        advance   = 1'b0;
        lrst_d    = 1'b0;

        unique case (state_q)
            OFF: begin
                state_d = INIT;
            end
            INIT: begin
                tmr_load = 1'b1;
                state_d  = pause ? PAUSED : RUN;
            end
            RUN: begin
                if (pause) begin
                    state_d = PAUSED;
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    advance  = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            PAUSED: begin
                advance = step_req;
                if (!pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = OFF;
        endcase

        // Dropping enable overrides everything decided above.
        if (!enable) begin
            state_d  = OFF;
            tmr_load = 1'b0;
            tmr_dec  = 1'b0;
            advance  = 1'b0;
        end

        if (state_d == INIT) begin
            lrst_d   = 1'b1;
            colour_d = 3'(COLOUR_FIRST);
        end

        if (advance) begin
            colour_d = (colour_q == 3'(COLOUR_LAST)) ? 3'(COLOUR_FIRST) : colour_q + 3'd1;
        end

        button_d  = advance;
        running_d = (state_d == RUN);
`ifdef LIGHT_SHOW_BLANK_EN
        sel_d     = (state_d != OFF) && !advance;
`else
        sel_d     = (state_d != OFF);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OFF;
            sel_q     <= 1'b0;
            button_q  <= 1'b0;
            lrst_q    <= 1'b0;
            running_q <= 1'b0;
            colour_q  <= 3'(COLOUR_FIRST);
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            button_q  <= button_d;
            lrst_q    <= lrst_d;
            running_q <= running_d;
            colour_q  <= colour_d;
        end
    end

    assign sel_o       = sel_q;
    assign button_o    = button_q;
    assign light_rst_o = lrst_q;
    assign running     = running_q;
    assign colour_idx  = colour_q;

endmodule
